// File: rtl/pc_flow_pkg.sv
// rtl/pc_flow_pkg.sv - shared types and defaults for the PC flow controller
package pc_flow_pkg;

  // Fetch-control state: normal issue, pipeline drain after halt, parked
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  // Cycles MEM/WB need to retire after a halt reaches EX
  localparam int DRAIN_CYC_DEFAULT = 2;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational redirect target select/add/truncate
module pc_target_calc #(
  parameter int PC_W = 9
) (
  input  logic            ex_jumpreg,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic [31:0]     ex_rs1,
  output logic [PC_W-1:0] target
);

  logic [31:0] jalr_sum;
  logic [31:0] pcrel_sum;
  logic        unused_sum_hi;

  assign jalr_sum  = ex_rs1 + ex_imm;
  assign pcrel_sum = 32'(ex_pc) + ex_imm;

  // Only the low PC_W bits form the target; the upper sum bits simply wrap away
  assign unused_sum_hi = ^{jalr_sum[31:PC_W], pcrel_sum[31:PC_W], jalr_sum[0]};

  // JALR wins over JAL/branch; JALR clears bit 0, JAL and branch share pc+imm
  always_comb begin
    target = pcrel_sum[PC_W-1:0];
    if (ex_jumpreg) begin
      target = {jalr_sum[PC_W-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - EX-stage redirect/flush/halt control (optional REDIRECT_STATS_EN counter)
module pc_flow_ctrl
  import pc_flow_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jumpreg,
  input  logic            ex_halt,
  input  logic            ex_br_taken,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic [31:0]     ex_rs1,
  output logic [PC_W-1:0] pc_next,
  output logic            pc_redirect,
  output logic            flush,
  output logic            pc_stall,
  output logic            halted
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_cnt
`endif
);

  localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  pc_state_e        state_q, state_d;
  logic             shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             redirect_req;
  logic             halt_acc;
  logic [PC_W-1:0]  target;

  // Reset also gates accept so every output reads zero while reset is held
  assign accept       = ~reset & ex_valid & ~shadow_q & (state_q == RUN);
  assign redirect_req = accept & ~ex_halt & (ex_jumpreg | ex_jump | (ex_branch & ex_br_taken));
  assign halt_acc     = accept & ex_halt;

  pc_target_calc #(.PC_W(PC_W)) u_target (
    .ex_jumpreg (ex_jumpreg),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .target     (target)
  );

  assign pc_redirect = redirect_req;
  assign pc_next     = redirect_req ? target : '0;
  assign flush       = redirect_req | shadow_q | halt_acc | (state_q != RUN);
  assign pc_stall    = halt_acc | (state_q != RUN);
  assign halted      = (state_q == HALTED);

  // The cycle after a redirect is a shadow: wrong-path fetch is flushed, EX ignored
  assign shadow_d = redirect_req;

  // Halt sequencing: RUN -> DRAIN (counted) -> HALTED, held until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (halt_acc) begin
          if (DRAIN_CYC == 0) begin
            state_d = HALTED;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYC);
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      shadow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef REDIRECT_STATS_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  assign redirect_cnt_d = redirect_req ? redirect_cnt_q + 32'd1 : redirect_cnt_q;

  // Free-running redirect tally, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt_q <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb/tb_pc_flow_ctrl.sv - randomized self-checking bench for pc_flow_ctrl
module tb_pc_flow_ctrl;

  localparam int PC_W      = 9;
  localparam int DRAIN_CYC = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid, ex_branch, ex_jump, ex_jumpreg, ex_halt, ex_br_taken;
  logic [PC_W-1:0] ex_pc;
  logic [31:0]     ex_imm, ex_rs1;
  logic [PC_W-1:0] pc_next;
  logic            pc_redirect, flush, pc_stall, halted;
`ifdef REDIRECT_STATS_EN
  logic [31:0]     redirect_cnt;
`endif

  pc_flow_ctrl #(.PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_jump     (ex_jump),
    .ex_jumpreg  (ex_jumpreg),
    .ex_halt     (ex_halt),
    .ex_br_taken (ex_br_taken),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .pc_next     (pc_next),
    .pc_redirect (pc_redirect),
    .flush       (flush),
    .pc_stall    (pc_stall),
    .halted      (halted)
`ifdef REDIRECT_STATS_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a cycle index plus timestamps of the last redirect and the halt
  int          cyc       = 0;
  int          last_redir = -10;
  int          halt_at   = -1;
  int          stat_cnt  = 0;
  bit          e_redir, e_acc_halt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PC_W-1:0] model_target(bit jr, logic [PC_W-1:0] pc,
                                                   logic [31:0] imm, logic [31:0] rs1);
    logic [31:0] s;
    if (jr) s = (rs1 + imm) & 32'hFFFF_FFFE;
    else    s = 32'(pc) + imm;
    return PC_W'(s % (1 << PC_W));
  endfunction

  task automatic drive(bit v, bit br, bit tk, bit j, bit jr, bit h,
                       logic [PC_W-1:0] pc, logic [31:0] imm, logic [31:0] rs1);
    ex_valid = v; ex_branch = br; ex_br_taken = tk; ex_jump = j; ex_jumpreg = jr; ex_halt = h;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
  endtask

  task automatic rand_ex(input bit allow_halt);
    logic [31:0] imm;
    imm = ($urandom_range(0, 1) == 1) ? $urandom : (($urandom & 32'h3F) - 32'd32);
    drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          allow_halt && ($urandom_range(0, 24) == 0), PC_W'($urandom), imm, $urandom);
  endtask

  // Compare every output against the model mid-cycle (on the falling edge)
  task automatic sample();
    bit shadow, stopped, acc, e_flush, e_stall, e_halted;
    logic [PC_W-1:0] e_next;
    @(negedge clk);
    if (reset) begin
      e_redir = 0; e_acc_halt = 0; e_flush = 0; e_stall = 0; e_halted = 0; e_next = '0;
    end else begin
      shadow     = (last_redir == cyc - 1);
      stopped    = (halt_at >= 0);
      acc        = ex_valid && !shadow && !stopped;
      e_redir    = acc && !ex_halt && (ex_jumpreg || ex_jump || (ex_branch && ex_br_taken));
      e_acc_halt = acc && ex_halt;
      e_flush    = e_redir || shadow || stopped || e_acc_halt;
      e_stall    = stopped || e_acc_halt;
      e_halted   = stopped && (cyc > halt_at + DRAIN_CYC);
      e_next     = e_redir ? model_target(ex_jumpreg, ex_pc, ex_imm, ex_rs1) : '0;
    end
    check("pc_redirect", pc_redirect, e_redir);
    check("pc_next", pc_next, e_next);
    check("flush", flush, e_flush);
    check("pc_stall", pc_stall, e_stall);
    check("halted", halted, e_halted);
`ifdef REDIRECT_STATS_EN
    check("redirect_cnt", redirect_cnt, reset ? 0 : stat_cnt);
`endif
  endtask

  task automatic advance();
    if (reset) begin
      last_redir = -10; halt_at = -1; stat_cnt = 0;
    end else begin
      if (e_redir) begin last_redir = cyc; stat_cnt++; end
      if (e_acc_halt) halt_at = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redir"}, pc_redirect, 0);
    check({tag, "_next"}, pc_next, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_stall"}, pc_stall, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
    sample();
    advance();
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 0, 0, 1, 0, 0, 9'h020, 32'd4, '0);
    repeat (2) @(posedge clk);
    #1;
    sample();
    check_all_zero("reset");
    advance();
    reset = 1'b0;

    // Taken branch with negative offset, then the shadow cycle swallows a jump
    drive(1, 1, 1, 0, 0, 0, 9'h040, 32'hFFFF_FFF8, '0);
    sample();
    check("br_redirect", pc_redirect, 1);
    check("br_next", pc_next, 9'h038);
    check("br_flush", flush, 1);
    advance();
    drive(1, 0, 0, 1, 0, 0, 9'h100, 32'd16, '0);
    sample();
    check("shadow_redirect", pc_redirect, 0);
    check("shadow_flush", flush, 1);
    advance();

    // JALR clears bit 0 and outranks JAL; JAL wraps at PC_W bits
    drive(1, 0, 0, 1, 1, 0, 9'h000, 32'd2, 32'h105);
    sample();
    check("jalr_next", pc_next, 9'h106);
    advance();
    idle();
    drive(1, 0, 0, 1, 0, 0, 9'h1F0, 32'h20, '0);
    sample();
    check("jal_wrap_next", pc_next, 9'h010);
    advance();
    idle();

    // Not-taken branch and a bubble carrying a jump bit do nothing
    drive(1, 1, 0, 0, 0, 0, 9'h080, 32'd8, '0);
    sample();
    check("nt_redirect", pc_redirect, 0);
    check("nt_flush", flush, 0);
    advance();
    drive(0, 0, 0, 1, 0, 0, 9'h080, 32'd8, '0);
    sample();
    check("bubble_redirect", pc_redirect, 0);
    check("bubble_flush", flush, 0);
    advance();

`ifdef REDIRECT_STATS_EN
    reset = 1'b1;
    idle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 0, PC_W'(i * 8), 32'd4, '0);
      sample();
      advance();
      idle();
    end
    check("stats_five", redirect_cnt, 5);
`endif

    // Halt combined with a taken branch: halt only, then drain, then parked
    drive(1, 1, 1, 0, 0, 1, 9'h040, 32'd8, '0);
    sample();
    check("halt_redirect", pc_redirect, 0);
    check("halt_stall", pc_stall, 1);
    advance();
    for (int k = 1; k <= 3; k++) begin
      rand_ex(0);
      sample();
      check("halt_timing", halted, (k == DRAIN_CYC + 1));
      advance();
    end
    for (int k = 0; k < 20; k++) begin
      rand_ex(1);
      sample();
      check("halt_hold", halted, 1);
      advance();
    end

    // Asynchronous reset out of HALTED
    reset = 1'b1;
    #1;
    check_all_zero("rst_halted");
    sample();
    advance();
    reset = 1'b0;

    // Reset mid-DRAIN, then a taken branch redirects right away
    drive(1, 0, 0, 0, 0, 1, '0, '0, '0);
    sample();
    advance();
    rand_ex(0);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("rst_drain");
    sample();
    advance();
    reset = 1'b0;
    drive(1, 1, 1, 0, 0, 0, 9'h040, 32'hFFFF_FFF8, '0);
    sample();
    check("post_rst_redirect", pc_redirect, 1);
    check("post_rst_next", pc_next, 9'h038);
    advance();

    // Random traffic with occasional halts, recovered by reset pulses
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 40; k++) begin
        rand_ex(1);
        sample();
        advance();
      end
      reset = 1'b1;
      sample();
      advance();
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
